// File: rtl/gb_cart_bus_master.sv
// rtl/gb_cart_bus_master.sv - Game Boy cartridge bus initiator with programmable setup/strobe/hold timing
module gb_cart_bus_master #(
  parameter int T_SETUP  = 4,
  parameter int T_STROBE = 12,
  parameter int T_HOLD   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic [15:0] address,
  inout  wire  [7:0]  data,
  output logic        nWR,
  output logic        nRD,
  output logic        nCS,
  output logic        OE
);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE} state_t;

  localparam logic [7:0] SETUP_LD  = 8'(T_SETUP - 1);
  localparam logic [7:0] STROBE_LD = 8'(T_STROBE - 1);
  localparam logic [7:0] HOLD_LD   = 8'(T_HOLD - 1);

  state_t      state, state_next;
  logic [7:0]  cnt, cnt_next;
  logic        wr_q, wr_next;
  logic [7:0]  wdata_q, wdata_next;
  logic [15:0] address_next;
  logic        nwr_next, nrd_next, ncs_next, oe_next;
  logic        req_ready_next, rsp_valid_next;
  logic [7:0]  rsp_rdata_next;
  logic        accept;
  logic        in_ram;

  assign accept = req_valid && req_ready;
  // External RAM window 0xA000..0xBFFF
  assign in_ram = (req_addr[15:13] == 3'b101);
  assign data   = OE ? wdata_q : 8'hzz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      wr_q      <= 1'b0;
      wdata_q   <= 8'h00;
      address   <= 16'h0000;
      nWR       <= 1'b1;
      nRD       <= 1'b1;
      nCS       <= 1'b1;
      OE        <= 1'b0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'h00;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      wr_q      <= wr_next;
      wdata_q   <= wdata_next;
      address   <= address_next;
      nWR       <= nwr_next;
      nRD       <= nrd_next;
      nCS       <= ncs_next;
      OE        <= oe_next;
      req_ready <= req_ready_next;
      rsp_valid <= rsp_valid_next;
      rsp_rdata <= rsp_rdata_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = SETUP;
          cnt_next   = SETUP_LD;
        end
      end
      SETUP: begin
        if (cnt == 8'd0) begin
          state_next = STROBE;
          cnt_next   = STROBE_LD;
        end else begin
          cnt_next = cnt - 8'd1;
        end
      end
      STROBE: begin
        if (cnt == 8'd0) begin
          state_next = HOLD;
          cnt_next   = HOLD_LD;
        end else begin
          cnt_next = cnt - 8'd1;
        end
      end
      HOLD: begin
        if (cnt == 8'd0) begin
          state_next = DONE;
          cnt_next   = 8'd0;
        end else begin
          cnt_next = cnt - 8'd1;
        end
      end
      DONE: begin
        state_next = IDLE;
        cnt_next   = 8'd0;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 8'd0;
      end
    endcase
  end

  // Next values of the registered outputs; each phase only touches what changes at its exit edge
  always_comb begin
    wr_next        = wr_q;
    wdata_next     = wdata_q;
    address_next   = address;
    nwr_next       = nWR;
    nrd_next       = nRD;
    ncs_next       = nCS;
    oe_next        = OE;
    req_ready_next = req_ready;
    rsp_valid_next = 1'b0;
    rsp_rdata_next = rsp_rdata;
    case (state)
      IDLE: begin
        if (accept) begin
          wr_next        = req_write;
          wdata_next     = req_wdata;
          address_next   = req_addr;
          ncs_next       = ~in_ram;
          oe_next        = req_write;
          req_ready_next = 1'b0;
        end
      end
      SETUP: begin
        if (cnt == 8'd0) begin
          nrd_next = wr_q;
          nwr_next = ~wr_q;
        end
      end
      STROBE: begin
        if (cnt == 8'd0) begin
          nrd_next = 1'b1;
          nwr_next = 1'b1;
          if (!wr_q) rsp_rdata_next = data;
        end
      end
      HOLD: begin
        if (cnt == 8'd0) begin
          rsp_valid_next = 1'b1;
          address_next   = 16'h0000;
          ncs_next       = 1'b1;
          oe_next        = 1'b0;
        end
      end
      DONE: begin
        req_ready_next = 1'b1;
      end
      default: begin
        req_ready_next = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_gb_cart_bus_master.sv
// tb/tb_gb_cart_bus_master.sv - scoreboard bench: default-timing DUT (a) and all-ones-timing DUT (b)
module tb_gb_cart_bus_master;

  typedef struct {
    int         id;
    logic [7:0] rdata;
    logic [7:0] wdata;
    int         delay;
    int         ss;
    int         nrd;
    int         nwr;
    int         ncs;
    int         oe;
    int         gap;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  logic        rv_a = 1'b0, wr_a = 1'b0, rv_b = 1'b0, wr_b = 1'b0;
  logic [15:0] addr_a = 16'h0, addr_b = 16'h0;
  logic [7:0]  wd_a = 8'h0, wd_b = 8'h0;
  logic        rdy_a, rdy_b, rspv_a, rspv_b;
  logic [7:0]  rdata_a, rdata_b;
  logic [15:0] pa_a, pa_b;
  wire  [7:0]  data_a, data_b;
  logic        nwr_a, nrd_a, ncs_a, oe_a, nwr_b, nrd_b, ncs_b, oe_b;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gb_cart_bus_master dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(rv_a), .req_ready(rdy_a), .req_write(wr_a),
    .req_addr(addr_a), .req_wdata(wd_a), .rsp_valid(rspv_a), .rsp_rdata(rdata_a),
    .address(pa_a), .data(data_a), .nWR(nwr_a), .nRD(nrd_a), .nCS(ncs_a), .OE(oe_a)
  );

  gb_cart_bus_master #(.T_SETUP(1), .T_STROBE(1), .T_HOLD(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(rv_b), .req_ready(rdy_b), .req_write(wr_b),
    .req_addr(addr_b), .req_wdata(wd_b), .rsp_valid(rspv_b), .rsp_rdata(rdata_b),
    .address(pa_b), .data(data_b), .nWR(nwr_b), .nRD(nrd_b), .nCS(ncs_b), .OE(oe_b)
  );

  function automatic logic [7:0] cart(input logic [15:0] a);
    if (a == 16'h0134) return 8'h54;
    return a[15:8] + a[7:0];
  endfunction

  assign data_a = (!nrd_a && !oe_a) ? cart(pa_a) : 8'hzz;
  assign data_b = (!nrd_b && !oe_b) ? cart(pa_b) : 8'hzz;

  logic       s_nrd[2], s_nwr[2], s_ncs[2], s_oe[2], s_rdy[2], s_rv[2], s_req[2];
  logic [7:0] s_data[2], s_rdata[2];
  assign s_nrd[0] = nrd_a;   assign s_nrd[1] = nrd_b;
  assign s_nwr[0] = nwr_a;   assign s_nwr[1] = nwr_b;
  assign s_ncs[0] = ncs_a;   assign s_ncs[1] = ncs_b;
  assign s_oe[0]  = oe_a;    assign s_oe[1]  = oe_b;
  assign s_rdy[0] = rdy_a;   assign s_rdy[1] = rdy_b;
  assign s_rv[0]  = rspv_a;  assign s_rv[1]  = rspv_b;
  assign s_req[0] = rv_a;    assign s_req[1] = rv_b;
  assign s_data[0] = data_a; assign s_data[1] = data_b;
  assign s_rdata[0] = rdata_a; assign s_rdata[1] = rdata_b;

  exp_t sb[2][$];

  task automatic chk(input int id, input string what, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL t%0d %s actual=%0h expected=%0h", id, what, act, exp);
    end
  endtask

  // Monitor: per-transaction pin statistics, compared against the scoreboard on rsp_valid
  int acc[2], gap[2], first_lo[2], nrd_lo[2], nwr_lo[2], ncs_lo[2], oe_hi[2], data_ok[2], bad[2], rdy_hi[2];

  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        first_lo[k] = -1; nrd_lo[k] = 0; nwr_lo[k] = 0; ncs_lo[k] = 0; oe_hi[k] = 0;
        data_ok[k] = 0; bad[k] = 0; rdy_hi[k] = 0; gap[k] = -1;
      end else begin
        if (!s_nrd[k]) nrd_lo[k]++;
        if (!s_nwr[k]) nwr_lo[k]++;
        if (!s_ncs[k]) ncs_lo[k]++;
        if (s_oe[k]) oe_hi[k]++;
        if (s_rdy[k]) rdy_hi[k]++;
        if ((!s_nrd[k] || !s_nwr[k]) && first_lo[k] < 0) first_lo[k] = cyc - acc[k];
        if (s_oe[k] && !s_nrd[k]) bad[k]++;
        if (!s_nrd[k] && !s_nwr[k]) bad[k]++;
        if (s_oe[k] && sb[k].size() > 0 && s_data[k] == sb[k][0].wdata) data_ok[k]++;
        if (s_rv[k]) begin
          if (sb[k].size() == 0) begin
            chk(-1, "unexpected_rsp", 1, 0);
          end else begin
            e = sb[k].pop_front();
            chk(e.id, "rsp_rdata", int'(s_rdata[k]), int'(e.rdata));
            chk(e.id, "rsp_edge", cyc + 1 - acc[k], e.delay);
            chk(e.id, "strobe_start", first_lo[k], e.ss);
            chk(e.id, "nrd_low_cycles", nrd_lo[k], e.nrd);
            chk(e.id, "nwr_low_cycles", nwr_lo[k], e.nwr);
            chk(e.id, "ncs_low_cycles", ncs_lo[k], e.ncs);
            chk(e.id, "oe_high_cycles", oe_hi[k], e.oe);
            chk(e.id, "data_driven_ok", data_ok[k], e.oe);
            chk(e.id, "bus_conflicts", bad[k], 0);
            chk(e.id, "ready_while_busy", rdy_hi[k], 0);
            if (e.gap >= 0) chk(e.id, "accept_gap", gap[k], e.gap);
          end
        end
        if (s_req[k] && s_rdy[k]) begin
          gap[k] = (acc[k] > 0) ? cyc + 1 - acc[k] : -1;
          acc[k] = cyc + 1;
          first_lo[k] = -1; nrd_lo[k] = 0; nwr_lo[k] = 0; ncs_lo[k] = 0; oe_hi[k] = 0;
          data_ok[k] = 0; bad[k] = 0; rdy_hi[k] = 0;
        end
      end
    end
  end

  function automatic exp_t mk(input int id, input logic [7:0] rdata, input logic [7:0] wdata,
                              input int delay, input int ss, input int nrd, input int nwr,
                              input int ncs, input int oe, input int g);
    exp_t e;
    e.id = id; e.rdata = rdata; e.wdata = wdata; e.delay = delay; e.ss = ss;
    e.nrd = nrd; e.nwr = nwr; e.ncs = ncs; e.oe = oe; e.gap = g;
    return e;
  endfunction

  // Leaves req_valid high; the caller drops it or issues the next request
  task automatic issue(input int k, input bit w, input logic [15:0] a, input logic [7:0] d,
                       input bit push, input exp_t e);
    int n;
    if (push) sb[k].push_back(e);
    if (k == 0) begin wr_a = w; addr_a = a; wd_a = d; rv_a = 1'b1; end
    else        begin wr_b = w; addr_b = a; wd_b = d; rv_b = 1'b1; end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!s_rdy[k] && n < 200);
    if (n >= 200) chk(e.id, "accept_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int k);
    int n;
    n = 0;
    while (sb[k].size() > 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    chk(k, "drain_pending", sb[k].size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d expected=0", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk(0, "reset_address", int'(pa_a), 0);
    chk(0, "reset_nwr", int'(nwr_a), 1);
    chk(0, "reset_nrd", int'(nrd_a), 1);
    chk(0, "reset_ncs", int'(ncs_a), 1);
    chk(0, "reset_oe", int'(oe_a), 0);
    chk(0, "reset_ready", int'(rdy_a), 1);
    chk(0, "reset_rsp_valid", int'(rspv_a), 0);
    chk(0, "reset_rsp_rdata", int'(rdata_a), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 1: read 0134 -> 54
    issue(0, 1'b0, 16'h0134, 8'h00, 1'b1, mk(1, 8'h54, 8'h00, 21, 4, 12, 0, 0, 0, -1));
    rv_a = 1'b0;
    drain(0);
    // 2: write 2000 = 01, rsp_rdata keeps 54
    issue(0, 1'b1, 16'h2000, 8'h01, 1'b1, mk(2, 8'h54, 8'h01, 21, 4, 0, 12, 0, 20, -1));
    rv_a = 1'b0;
    drain(0);
    // 3: external RAM boundary
    issue(0, 1'b0, 16'hA000, 8'h00, 1'b1, mk(3, 8'hA0, 8'h00, 21, 4, 12, 0, 20, 0, -1));
    rv_a = 1'b0;
    drain(0);
    issue(0, 1'b0, 16'h9FFF, 8'h00, 1'b1, mk(4, 8'h9E, 8'h00, 21, 4, 12, 0, 0, 0, -1));
    rv_a = 1'b0;
    drain(0);
    // 4: req_valid held across two reads
    issue(0, 1'b0, 16'h4000, 8'h00, 1'b1, mk(5, 8'h40, 8'h00, 21, 4, 12, 0, 0, 0, -1));
    issue(0, 1'b0, 16'h4001, 8'h00, 1'b1, mk(6, 8'h41, 8'h00, 21, 4, 12, 0, 0, 0, 22));
    rv_a = 1'b0;
    drain(0);
    // 5: reset during the strobe of a RAM read; no response may follow
    issue(0, 1'b0, 16'hA123, 8'h00, 1'b0, mk(7, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, -1));
    rv_a = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk(7, "strobe_active_before_reset", int'(nrd_a), 0);
    #1;
    rst_n = 1'b0;
    #1;
    chk(7, "async_nrd_high", int'(nrd_a), 1);
    chk(7, "async_ncs_high", int'(ncs_a), 1);
    chk(7, "async_oe_low", int'(oe_a), 0);
    chk(7, "async_rsp_valid", int'(rspv_a), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk(7, "ready_after_release", int'(rdy_a), 1);
    repeat (30) @(posedge clk);
    #1;
    issue(0, 1'b0, 16'h0150, 8'h00, 1'b1, mk(8, 8'h51, 8'h00, 21, 4, 12, 0, 0, 0, -1));
    rv_a = 1'b0;
    drain(0);
    // 6: minimum timing, held request for the next-accept spacing
    issue(1, 1'b0, 16'h0134, 8'h00, 1'b1, mk(9, 8'h54, 8'h00, 4, 1, 1, 0, 0, 0, -1));
    issue(1, 1'b0, 16'h0200, 8'h00, 1'b1, mk(10, 8'h02, 8'h00, 4, 1, 1, 0, 0, 0, 5));
    rv_b = 1'b0;
    drain(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
